// File: rtl/sim_run_controller.sv
// sim_run_controller: run sequencer that resets the harness, counts run cycles, gates the dump window and resolves pass/fail/timeout.
// Ports: clock/reset (sync, active-low); cfg_valid/cfg_ready with cfg_max_cycles, cfg_dump_start, cfg_dump_len;
// harness_reset to the harness; dut_success/dut_failure from the harness; dump_en, cycle_count, status
// (0 none, 1 pass, 2 fail, 3 timeout); finish_req/finish_ack handshake with the environment.
module sim_run_controller #(
  parameter int CNT_W        = 64,
  parameter int RESET_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_max_cycles,
  input  logic [CNT_W-1:0] cfg_dump_start,
  input  logic [CNT_W-1:0] cfg_dump_len,
  output logic             harness_reset,
  input  logic             dut_success,
  input  logic             dut_failure,
  output logic             dump_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       status,
  output logic             finish_req,
  input  logic             finish_ack
);
  typedef enum logic [1:0] {IDLE, RESET_DUT, RUN, DONE} state_t;
  state_t           state, state_next;
  logic [7:0]       rst_cnt, rst_cnt_next;
  logic [CNT_W-1:0] cnt_next, max_cycles, dump_start, dump_len, max_next, start_next, len_next;
  logic [1:0]       status_next;
  logic             timeout, in_window;
  assign timeout   = (max_cycles != '0) && (cycle_count > max_cycles);
  // window end computed one bit wider so dump_start + dump_len cannot wrap
  assign in_window = (cycle_count >= dump_start) &&
                     ((dump_len == '0) || ({1'b0, cycle_count} < ({1'b0, dump_start} + {1'b0, dump_len})));
  assign cfg_ready     = state == IDLE;
  assign harness_reset = (state == IDLE) || (state == RESET_DUT);
  assign finish_req    = state == DONE;
  assign dump_en       = (dump_start == '0) ? ((state == RESET_DUT) || (state == RUN)) : ((state == RUN) && in_window);
  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    cnt_next     = cycle_count;
    status_next  = status;
    max_next     = max_cycles;
    start_next   = dump_start;
    len_next     = dump_len;
    case (state)
      IDLE:
        if (cfg_valid) begin
          max_next     = cfg_max_cycles;
          start_next   = cfg_dump_start;
          len_next     = cfg_dump_len;
          status_next  = 2'd0;
          rst_cnt_next = 8'd0;
          state_next   = RESET_DUT;
        end
      RESET_DUT:
        if (rst_cnt == 8'(RESET_CYCLES - 1)) begin
          state_next = RUN;
          cnt_next   = CNT_W'(1);
        end else
          rst_cnt_next = rst_cnt + 8'd1;
      RUN:
        if (dut_failure || timeout || dut_success) begin
          state_next  = DONE;
          status_next = dut_failure ? 2'd2 : timeout ? 2'd3 : 2'd1;
        end else
          cnt_next = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
      DONE:
        if (finish_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      rst_cnt     <= 8'd0;
      cycle_count <= '0;
      status      <= 2'd0;
      max_cycles  <= '0;
      dump_start  <= '0;
      dump_len    <= '0;
    end else begin
      state       <= state_next;
      rst_cnt     <= rst_cnt_next;
      cycle_count <= cnt_next;
      status      <= status_next;
      max_cycles  <= max_next;
      dump_start  <= start_next;
      dump_len    <= len_next;
    end
  end
endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: directed self-checking bench for sim_run_controller.
module tb_sim_run_controller;
  localparam int CNT_W = 64;
  logic             clock = 0, reset = 0, cfg_valid = 0, dut_success = 0, dut_failure = 0, finish_ack = 0;
  logic [CNT_W-1:0] cfg_max_cycles = '0, cfg_dump_start = '0, cfg_dump_len = '0;
  logic             cfg_ready, harness_reset, dump_en, finish_req;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       status;
  int               passed = 0, total = 0;
  sim_run_controller #(.CNT_W(CNT_W), .RESET_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start), .cfg_dump_len(cfg_dump_len),
    .harness_reset(harness_reset), .dut_success(dut_success), .dut_failure(dut_failure),
    .dump_en(dump_en), .cycle_count(cycle_count), .status(status),
    .finish_req(finish_req), .finish_ack(finish_ack)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic start_run(input logic [CNT_W-1:0] mx, input logic [CNT_W-1:0] ds, input logic [CNT_W-1:0] dl, output int hr_cycles);
    cfg_valid = 1; cfg_max_cycles = mx; cfg_dump_start = ds; cfg_dump_len = dl;
    tick();
    cfg_valid = 0; cfg_max_cycles = '0; cfg_dump_start = '0; cfg_dump_len = '0;
    hr_cycles = 0;
    while (harness_reset && hr_cycles < 50) begin
      hr_cycles++;
      tick();
    end
  endtask
  task automatic run_to(input logic [CNT_W-1:0] target);
    int n = 0;
    while (cycle_count != target && n < 500) begin
      n++;
      tick();
    end
  endtask
  task automatic ack();
    finish_ack = 1;
    tick();
    finish_ack = 0;
  endtask
  task automatic test_reset();
    reset = 0;
    tick(); tick();
    total++; if (cfg_ready !== 1'b1 || harness_reset !== 1'b1) $display("FAIL reset_ctl ready=%b hr=%b required 1 1", cfg_ready, harness_reset); else passed++;
    total++; if (cycle_count !== '0 || status !== 2'd0) $display("FAIL reset_cnt cc=%0d st=%0d required 0 0", cycle_count, status); else passed++;
    total++; if (finish_req !== 1'b0 || dump_en !== 1'b0) $display("FAIL reset_out fr=%b de=%b required 0 0", finish_req, dump_en); else passed++;
    reset = 1;
    tick();
  endtask
  task automatic test_pass();
    int hr;
    start_run('0, 64'd100, '0, hr);
    total++; if (hr !== 8) $display("FAIL pass_hr_cycles got %0d required 8", hr); else passed++;
    total++; if (cycle_count !== 64'd1) $display("FAIL pass_first_count got %0d required 1", cycle_count); else passed++;
    run_to(64'd20);
    dut_success = 1;
    tick();
    dut_success = 0;
    total++; if (finish_req !== 1'b1 || status !== 2'd1) $display("FAIL pass_done fr=%b st=%0d required 1 1", finish_req, status); else passed++;
    total++; if (cycle_count !== 64'd20) $display("FAIL pass_count got %0d required 20", cycle_count); else passed++;
    tick();
    total++; if (finish_req !== 1'b1 || cycle_count !== 64'd20) $display("FAIL pass_hold fr=%b cc=%0d required 1 20", finish_req, cycle_count); else passed++;
    ack();
    total++; if (finish_req !== 1'b0 || harness_reset !== 1'b1 || cfg_ready !== 1'b1) $display("FAIL pass_ack fr=%b hr=%b rdy=%b required 0 1 1", finish_req, harness_reset, cfg_ready); else passed++;
  endtask
  task automatic test_simultaneous();
    int hr;
    start_run('0, 64'd100, '0, hr);
    run_to(64'd5);
    dut_success = 1; dut_failure = 1;
    tick();
    dut_success = 0; dut_failure = 0;
    total++; if (status !== 2'd2 || cycle_count !== 64'd5) $display("FAIL simul st=%0d cc=%0d required 2 5", status, cycle_count); else passed++;
    ack();
  endtask
  task automatic test_timeout();
    int hr, n = 0;
    start_run(64'd10, 64'd100, '0, hr);
    while (!finish_req && n < 100) begin
      n++;
      tick();
    end
    total++; if (status !== 2'd3 || cycle_count !== 64'd11) $display("FAIL timeout st=%0d cc=%0d required 3 11", status, cycle_count); else passed++;
    ack();
    total++; if (harness_reset !== 1'b1 || status !== 2'd3 || cycle_count !== 64'd11) $display("FAIL timeout_idle hr=%b st=%0d cc=%0d required 1 3 11", harness_reset, status, cycle_count); else passed++;
    dut_success = 1; dut_failure = 1;
    tick();
    dut_success = 0; dut_failure = 0;
    total++; if (status !== 2'd3 || finish_req !== 1'b0) $display("FAIL idle_ignore st=%0d fr=%b required 3 0", status, finish_req); else passed++;
  endtask
  task automatic test_dump_window();
    int hr, bad = 0;
    logic exp_de;
    cfg_valid = 1; cfg_dump_start = 64'd5; cfg_dump_len = 64'd3;
    tick();
    cfg_valid = 0; cfg_dump_start = '0; cfg_dump_len = '0;
    total++; if (dump_en !== 1'b0) $display("FAIL win_resetdut got %b required 0", dump_en); else passed++;
    while (harness_reset && hr < 50) begin hr++; tick(); end
    for (int c = 1; c <= 12; c++) begin
      exp_de = (c >= 5) && (c < 8);
      total++; if (cycle_count !== 64'(c) || dump_en !== exp_de) $display("FAIL win_cycle cc=%0d de=%b required cc=%0d de=%b", cycle_count, dump_en, c, exp_de); else passed++;
      if (c == 12) dut_success = 1;
      tick();
    end
    dut_success = 0;
    total++; if (dump_en !== 1'b0 || finish_req !== 1'b1) $display("FAIL win_done de=%b fr=%b required 0 1", dump_en, finish_req); else passed++;
    ack();
  endtask
  task automatic test_dump_from_reset();
    int n = 0;
    total++; if (dump_en !== 1'b0) $display("FAIL dz_idle got %b required 0", dump_en); else passed++;
    cfg_valid = 1;
    tick();
    cfg_valid = 0;
    while (harness_reset && n < 50) begin
      total++; if (dump_en !== 1'b1) $display("FAIL dz_resetdut got %b required 1", dump_en); else passed++;
      n++;
      tick();
    end
    run_to(64'd4);
    total++; if (dump_en !== 1'b1 || harness_reset !== 1'b0) $display("FAIL dz_run de=%b hr=%b required 1 0", dump_en, harness_reset); else passed++;
    dut_success = 1;
    tick();
    dut_success = 0;
    total++; if (dump_en !== 1'b0 || status !== 2'd1) $display("FAIL dz_done de=%b st=%0d required 0 1", dump_en, status); else passed++;
    ack();
    total++; if (dump_en !== 1'b0) $display("FAIL dz_after got %b required 0", dump_en); else passed++;
  endtask
  task automatic test_abort();
    int hr;
    start_run('0, 64'd100, '0, hr);
    run_to(64'd30);
    total++; if (cfg_ready !== 1'b0) $display("FAIL run_ready got %b required 0", cfg_ready); else passed++;
    cfg_valid = 1; cfg_max_cycles = 64'd5; cfg_dump_start = 64'd31; cfg_dump_len = 64'd2;
    tick();
    cfg_valid = 0; cfg_max_cycles = '0; cfg_dump_start = '0; cfg_dump_len = '0;
    run_to(64'd50);
    total++; if (status !== 2'd0 || finish_req !== 1'b0 || dump_en !== 1'b0 || cycle_count !== 64'd50) $display("FAIL cfg_ignored st=%0d fr=%b de=%b cc=%0d required 0 0 0 50", status, finish_req, dump_en, cycle_count); else passed++;
    reset = 0;
    tick();
    total++; if (harness_reset !== 1'b1 || cfg_ready !== 1'b1 || status !== 2'd0 || finish_req !== 1'b0 || cycle_count !== '0) $display("FAIL abort hr=%b rdy=%b st=%0d fr=%b cc=%0d required 1 1 0 0 0", harness_reset, cfg_ready, status, finish_req, cycle_count); else passed++;
    reset = 1;
    tick();
    total++; if (cfg_ready !== 1'b1 || finish_req !== 1'b0) $display("FAIL abort_stay rdy=%b fr=%b required 1 0", cfg_ready, finish_req); else passed++;
  endtask
  initial begin
    test_reset();
    test_pass();
    test_simultaneous();
    test_timeout();
    test_dump_window();
    test_dump_from_reset();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
